lif_sweep_ctrl: RTL and testbench
=================================

# lif_sweep_ctrl

Sequencer that owns the single-port neuron-state SRAM and performs one leaky-integrate-and-fire update sweep over every neuron per timestep `tick`. For each address it reads membrane potential, applies leak and input current with saturation, compares against threshold, writes the result back, and emits a spike event. It sits between the timestep generator/synapse accumulator and the `sram` instance holding membrane potentials.

## Interface
- `WIDTH`, 32, membrane potential / current width (signed two's complement)
- `DEPTH`, 256, number of neurons (SRAM words); `AW = $clog2(DEPTH)`
- `LEAK_SHIFT`, 4, leak = `v >>> LEAK_SHIFT`
- `THRESHOLD`, 1000, spike threshold (signed)
- `V_RESET`, 0, potential written after a spike

- `clk` in 1: clock
- `reset` in 1: asynchronous, active-high
- `tick` in 1: start-sweep request (single-cycle pulse)
- `in_current` in WIDTH: signed input current for neuron `sram_addr`; must be valid combinationally in UPDATE cycles
- `sram_rdata` in WIDTH: SRAM `word` output
- `sram_we` out 1: SRAM `write_enable`
- `sram_addr` out AW: SRAM `addr`; also the current-request address
- `sram_wdata` out WIDTH: SRAM `write_word`
- `busy` out 1: sweep in progress
- `done` out 1: one-cycle pulse after the last write-back
- `spike_valid` out 1: one-cycle spike strobe
- `spike_addr` out AW: neuron index of spike
- `overrun` out 1: sticky, `tick` arrived while busy (see Configuration)

## Operation
- FSM states: IDLE, READ, UPDATE, DONE.
- IDLE: `idx`=0; on `tick` -> READ, `busy`=1.
- READ: `sram_addr`=`idx`, `sram_we`=0 -> UPDATE.
- UPDATE: `sram_rdata` = mem[idx]; compute `v_next = sat(v - (v >>> LEAK_SHIFT) + in_current)` in WIDTH+2 bits, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. If `v_next >= THRESHOLD`: `sram_wdata`=`V_RESET`, `spike_valid`=1, `spike_addr`=`idx`; else `sram_wdata`=`v_next`. `sram_we`=1, `sram_addr`=`idx`. If `idx==DEPTH-1` -> DONE, else `idx++` -> READ.
- DONE: `done`=1, `busy`=0 -> IDLE. A `tick` in DONE is treated as a tick while busy.
- `tick` in READ/UPDATE/DONE ignored (sweep is never restarted).
- Reset (any time, including mid-sweep): state IDLE, `idx`=0. All outputs 0: `busy`, `done`, `sram_we`, `sram_addr`, `sram_wdata`, `spike_valid`, `spike_addr`, `overrun`. SRAM contents are reset by the SRAM itself; a partially swept timestep is discarded.

## Timing
- SRAM read latency 1 cycle; `sram_addr`, `sram_we`, `sram_wdata`, `spike_*` are registered or decoded from state/`idx` only, with no combinational path from `tick`.
- 2 cycles per neuron; `tick` at edge T -> first READ in cycle T+1, `done` high in cycle T+1+2·DEPTH. Minimum tick period 2·DEPTH+2 cycles.
- Write and read of the same address never occur in the same cycle, so the SRAM read-during-write behaviour does not apply.
- `spike_valid` coincides with the write-back cycle of that neuron.

## Configuration
- `LIF_SWEEP_OVERRUN_EN` defined: `overrun` is set on any `tick` while state ≠ IDLE and stays set until `reset`.
- Not defined: `overrun` tied to 0 and no detection logic is built. Port list is unchanged.

## Structure
- Package `lif_pkg`: FSM state enum (`LIF_IDLE`, `LIF_READ`, `LIF_UPDATE`, `LIF_DONE`) and the saturating-clamp function parameterised on width.
- Sub-module `lif_neuron_update`: combinational leak/integrate/saturate/threshold datapath (`v`, `in_current` -> `v_next`, `fire`). The FSM and counter stay in `lif_sweep_ctrl`.

## Test plan
Bench parameters: WIDTH=16, DEPTH=4, LEAK_SHIFT=2, THRESHOLD=100, V_RESET=0, with the real `sram` attached.
- Reset asserted -> all outputs 0. Release, no tick for 10 cycles -> `sram_we` stays 0.
- Memory all 0, `in_current`=40: tick → `done` exactly 9 cycles after the tick edge, memory = 40 in every word. Second tick → 70, third → 93, fourth → each neuron spikes, with `spike_addr` 0,1,2,3 and memory 0.
- Saturation: preload v=-32000, `in_current`=-32000 -> write -32768, no spike. Preload v=32000, `in_current`=32000 -> fires and writes 0.
- `tick` re-pulsed in cycles 3 and 9 of a sweep -> sweep completes unchanged. `overrun`=1 with the macro defined, 0 without it.
- Reset asserted during the UPDATE of neuron 1 -> `busy`=0 the same cycle. The next tick starts at `sram_addr`=0 and completes the full 4 neurons.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared FSM state encoding and saturating clamp for the LIF sweep controller.
// Imported by lif_sweep_ctrl and lif_neuron_update.
package lif_pkg;

    typedef enum logic [1:0] {
        LIF_IDLE,
        LIF_READ,
        LIF_UPDATE,
        LIF_DONE
    } lif_state_e;

    localparam int LIF_MAXW = 64;

    typedef logic signed [LIF_MAXW-1:0] lif_wide_t;

    // Clamp x to the signed range of a w-bit word (w <= LIF_MAXW).
    function automatic lif_wide_t lif_sat(input lif_wide_t x, input int unsigned w);
        lif_wide_t hi;
        lif_wide_t lo;
        hi = (lif_wide_t'(1) <<< (w - 1)) - lif_wide_t'(1);
        lo = -hi - lif_wide_t'(1);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/lif_neuron_update.sv
// Combinational leak / integrate / saturate / threshold datapath for one neuron.
module lif_neuron_update
    import lif_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int LEAK_SHIFT = 4,
    parameter int THRESHOLD  = 1000
) (
    input  logic [WIDTH-1:0] v_i,
    input  logic [WIDTH-1:0] in_current_i,
    output logic [WIDTH-1:0] v_next_o,
    output logic             fire_o
);

    localparam int SW = WIDTH + 2;
    localparam logic signed [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

    logic signed [WIDTH-1:0] v_s;
    logic signed [WIDTH-1:0] cur_s;
    logic signed [WIDTH-1:0] leak_s;
    logic signed [SW-1:0]    sum_s;

    assign v_s    = v_i;
    assign cur_s  = in_current_i;
    assign leak_s = v_s >>> LEAK_SHIFT;

    // Two guard bits hold the worst case of v - leak + current exactly.
    assign sum_s = SW'(v_s) - SW'(leak_s) + SW'(cur_s);

    assign v_next_o = WIDTH'(lif_sat(LIF_MAXW'(sum_s), WIDTH));
    assign fire_o   = $signed(v_next_o) >= THR;

endmodule

// File: rtl/lif_sweep_ctrl.sv
// LIF neuron-state sweep sequencer: one read/update pass over the SRAM per tick.
// Define LIF_SWEEP_OVERRUN_EN to build the sticky tick-while-busy overrun flag.
module lif_sweep_ctrl
    import lif_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int LEAK_SHIFT = 4,
    parameter int THRESHOLD  = 1000,
    parameter int V_RESET    = 0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [WIDTH-1:0] in_current,
    input  logic [WIDTH-1:0] sram_rdata,
    output logic             sram_we,
    output logic [AW-1:0]    sram_addr,
    output logic [WIDTH-1:0] sram_wdata,
    output logic             busy,
    output logic             done,
    output logic             spike_valid,
    output logic [AW-1:0]    spike_addr,
    output logic             overrun
);

    localparam logic [AW-1:0]    LAST = AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] VRST = WIDTH'(V_RESET);

    lif_state_e       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] v_next;
    logic             fire;

    lif_neuron_update #(
        .WIDTH      (WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT),
        .THRESHOLD  (THRESHOLD)
    ) u_update (
        .v_i          (sram_rdata),
        .in_current_i (in_current),
        .v_next_o     (v_next),
        .fire_o       (fire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LIF_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs decode from state/idx only, so tick never reaches the SRAM port.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy        = 1'b0;
        done        = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = '0;
        sram_wdata  = '0;
        spike_valid = 1'b0;
        spike_addr  = '0;
        unique case (state_q)
            LIF_IDLE: begin
                idx_d = '0;
                if (tick) state_d = LIF_READ;
            end
            LIF_READ: begin
                busy      = 1'b1;
                sram_addr = idx_q;
                state_d   = LIF_UPDATE;
            end
            LIF_UPDATE: begin
                busy        = 1'b1;
                sram_we     = 1'b1;
                sram_addr   = idx_q;
                sram_wdata  = fire ? VRST : v_next;
                spike_valid = fire;
                spike_addr  = fire ? idx_q : '0;
                if (idx_q == LAST) begin
                    state_d = LIF_DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = LIF_READ;
                end
            end
            LIF_DONE: begin
                done    = 1'b1;
                state_d = LIF_IDLE;
            end
            default: state_d = LIF_IDLE;
        endcase
    end

`ifdef LIF_SWEEP_OVERRUN_EN
    logic ovr_q, ovr_d;

    assign ovr_d = ovr_q | (tick & (state_q != LIF_IDLE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovr_q <= 1'b0;
        else       ovr_q <= ovr_d;
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_lif_sweep_ctrl.sv
// Scoreboard bench for lif_sweep_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_lif_sweep_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int LS    = 2;
    localparam int THR   = 100;
    localparam int VR    = 0;
    localparam int AW    = 2;
`ifdef LIF_SWEEP_OVERRUN_EN
    localparam int OVR_EXP = 1;
`else
    localparam int OVR_EXP = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic [WIDTH-1:0] in_current;
    logic [WIDTH-1:0] sram_rdata;
    logic             sram_we;
    logic [AW-1:0]    sram_addr;
    logic [WIDTH-1:0] sram_wdata;
    logic             busy, done, spike_valid, overrun;
    logic [AW-1:0]    spike_addr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cur_tab[DEPTH];
    int ref_mem[DEPTH];
    int pl_val[DEPTH];
    logic pl_go = 1'b0;
    logic [WIDTH-1:0] mem[DEPTH];

    typedef struct {
        bit is_done;
        int addr;
        int data;
        bit spk;
        int cyc;
    } ev_t;
    ev_t sbq[$];
    ev_t mon_e;

    lif_sweep_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LEAK_SHIFT(LS),
        .THRESHOLD(THR), .V_RESET(VR)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .in_current(in_current), .sram_rdata(sram_rdata),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .busy(busy), .done(done), .spike_valid(spike_valid),
        .spike_addr(spike_addr), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign in_current = 16'(cur_tab[sram_addr]);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            sram_rdata <= '0;
        end else if (pl_go) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 16'(pl_val[i]);
        end else begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            sram_rdata <= mem[sram_addr];
        end
    end

    function automatic void check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic void lif_ref(input int v, input int cur, output int wd, output bit spk);
        int n;
        n = v - floor_div(v, 1 << LS) + cur;
        if (n > 32767) n = 32767;
        if (n < -32768) n = -32768;
        spk = (n >= THR);
        wd  = spk ? VR : n;
    endfunction

    always @(negedge clk) begin
        if (!reset && (sram_we || done || spike_valid)) begin
            if (sbq.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                check("ev_cycle", cyc, mon_e.cyc);
                if (mon_e.is_done) begin
                    check("done", int'(done), 1);
                    check("done_we", int'(sram_we), 0);
                    check("done_busy", int'(busy), 0);
                end else begin
                    check("wr_we", int'(sram_we), 1);
                    check("wr_addr", int'(sram_addr), mon_e.addr);
                    check("wr_data", int'($signed(sram_wdata)), mon_e.data);
                    check("spike_valid", int'(spike_valid), int'(mon_e.spk));
                    if (mon_e.spk) check("spike_addr", int'(spike_addr), mon_e.addr);
                    check("wr_busy", int'(busy), 1);
                end
            end
        end
    end

    task automatic preload();
        @(negedge clk);
        pl_go = 1'b1;
        @(negedge clk);
        pl_go = 1'b0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = int'($signed(16'(pl_val[k])));
    endtask

    task automatic issue_tick(output int t);
        int wd;
        bit spk;
        @(negedge clk);
        t = cyc + 1;
        for (int k = 0; k < DEPTH; k++) begin
            lif_ref(ref_mem[k], cur_tab[k], wd, spk);
            sbq.push_back('{1'b0, k, wd, spk, t + 1 + 2 * k});
            ref_mem[k] = wd;
        end
        sbq.push_back('{1'b1, 0, 0, 1'b0, t + 2 * DEPTH});
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic sweep(input bit rep);
        int t;
        issue_tick(t);
        while (cyc < t + 2 * DEPTH + 4) begin
            @(negedge clk);
            tick = rep && (cyc == t + 2 || cyc == t + 8);
        end
        tick = 1'b0;
        check("sweep_drain", sbq.size(), 0);
        for (int k = 0; k < DEPTH; k++)
            check("mem_word", int'($signed(mem[k])), ref_mem[k]);
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int found;
        int exp_v[4];
        exp_v = '{40, 70, 93, 0};
        for (int k = 0; k < DEPTH; k++) begin
            cur_tab[k] = 0;
            ref_mem[k] = 0;
            pl_val[k]  = 0;
        end

        @(negedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(sram_we), 0);
        check("rst_addr", int'(sram_addr), 0);
        check("rst_wdata", int'(sram_wdata), 0);
        check("rst_spike", int'(spike_valid), 0);
        check("rst_spike_addr", int'(spike_addr), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_we", int'(sram_we), 0);
            check("idle_busy", int'(busy), 0);
        end

        for (int k = 0; k < DEPTH; k++) cur_tab[k] = 40;
        for (int s = 0; s < 4; s++) begin
            sweep(1'b0);
            for (int k = 0; k < DEPTH; k++)
                check("const_sweep", int'($signed(mem[k])), exp_v[s]);
        end
        check("ovr_after_clean", int'(overrun), 0);

        pl_val  = '{-32000, 32000, 50, -7};
        cur_tab = '{-32000, 32000, 3, 9};
        preload();
        sweep(1'b0);
        check("sat_neg", int'($signed(mem[0])), -32768);
        check("sat_pos_fire", int'($signed(mem[1])), 0);

        for (int k = 0; k < DEPTH; k++) cur_tab[k] = int'($urandom_range(200)) - 50;
        sweep(1'b1);
        check("overrun", int'(overrun), OVR_EXP);

        issue_tick(t);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (sram_we && sram_addr == 2'd1) found = 1;
        end
        check("reach_upd1", found, 1);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_we", int'(sram_we), 0);
        check("midrst_addr", int'(sram_addr), 0);
        check("midrst_ovr", int'(overrun), 0);
        sbq.delete();
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 0;
        @(negedge clk);
        reset = 1'b0;
        sweep(1'b0);

        for (int r = 0; r < 8; r++) begin
            if (r % 2 == 0) begin
                for (int k = 0; k < DEPTH; k++)
                    pl_val[k] = int'($urandom_range(65535)) - 32768;
                preload();
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (r % 3 == 0) cur_tab[k] = int'($urandom_range(65535)) - 32768;
                else            cur_tab[k] = int'($urandom_range(120)) - 30;
            end
            sweep(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
